// File: rtl/aes_inv_mix_columns_iter.sv
// Iterative AES InvMixColumns stage: takes one 128-bit state per handshake, transforms
// COLS_PER_CYCLE columns per cycle and holds the result until the consumer accepts it.
module aes_inv_mix_columns_iter #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_i,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_o
);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [2:0] ColStep = 3'(COLS_PER_CYCLE);

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    state_e       st_q, st_d;
    logic [2:0]   cnt_q, cnt_d;
    logic [127:0] work_q, work_d;
    logic [127:0] res_q, res_d;
    logic         ov_q, ov_d;
    logic [127:0] calc;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        logic [7:0] x2, x4, x8;
        for (int r = 0; r < 4; r++) begin
            a[r]  = c[31-8*r -: 8];
            x2    = xtime(a[r]);
            x4    = xtime(x2);
            x8    = xtime(x4);
            m9[r] = x8 ^ a[r];
            mb[r] = x8 ^ x2 ^ a[r];
            md[r] = x8 ^ x4 ^ a[r];
            me[r] = x8 ^ x4 ^ x2;
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    // Only the columns selected by the counter are replaced; the rest pass through.
    always_comb begin
        logic [2:0] idx;
        calc = work_q;
        for (int j = 0; j < 4; j++) begin
            idx = 3'(j);
            if (idx >= cnt_q && idx < cnt_q + ColStep) begin
                calc[127-32*j -: 32] = inv_col(work_q[127-32*j -: 32]);
            end
        end
    end

    always_comb begin
        st_d     = st_q;
        cnt_d    = cnt_q;
        work_d   = work_q;
        res_d    = res_q;
        ov_d     = ov_q;
        in_ready = 1'b0;
        if (en) begin
            case (st_q)
                StIdle: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        work_d = state_i;
                        cnt_d  = 3'd0;
                        st_d   = StCalc;
                    end
                end
                StCalc: begin
                    work_d = calc;
                    cnt_d  = cnt_q + ColStep;
                    if (cnt_q + ColStep == 3'd4) begin
                        res_d = calc;
                        ov_d  = 1'b1;
                        st_d  = StHold;
                    end
                end
                StHold: begin
                    in_ready = out_ready;
                    if (out_ready) begin
                        ov_d = 1'b0;
                        if (in_valid) begin
                            work_d = state_i;
                            cnt_d  = 3'd0;
                            st_d   = StCalc;
                        end else begin
                            st_d = StIdle;
                        end
                    end
                end
                default: st_d = StIdle;
            endcase
        end
        if (!rst_n) begin
            in_ready = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st_q   <= StIdle;
            cnt_q  <= 3'd0;
            work_q <= 128'h0;
            res_q  <= 128'h0;
            ov_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            work_q <= work_d;
            res_q  <= res_d;
            ov_q   <= ov_d;
        end
    end

    assign out_valid = ov_q;
    assign state_o   = res_q;

endmodule

// File: tb/tb_aes_inv_mix_columns_iter.sv
// Directed bench for aes_inv_mix_columns_iter: one instance per column width (1 and 4).
module tb_aes_inv_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;

    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [127:0] a_state_i, a_state_o;
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [127:0] b_state_i, b_state_o;

    int total = 0;
    int bad   = 0;
    int n;

    localparam logic [127:0] V1 = {32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'hd5d5d7d6};
    localparam logic [127:0] R1 = {32'hdb135345, 32'hf20a225c, 32'h01010101, 32'hd4d4d4d5};
    localparam logic [127:0] V2 = 128'h4c7a9ae526d3198106f8cb662848e004;
    localparam logic [127:0] V3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V4 = {32'hc6c6c6c6, 32'h01010101, 32'h8e4da1bc, 32'hd5d5d7d6};
    localparam logic [127:0] R4 = {32'hc6c6c6c6, 32'h01010101, 32'hdb135345, 32'hd4d4d4d5};

    always #5 clk = ~clk;

    aes_inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .state_i   (a_state_i),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .state_o   (a_state_o)
    );

    aes_inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .state_i   (b_state_i),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .state_o   (b_state_o)
    );

    // Generic shift-and-add GF(2^8) multiply, independent of the fixed xtime chain in the DUT.
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix(input logic [127:0] s, input logic inv);
        logic [7:0]   k [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (inv) begin
            k[0] = 8'h0e; k[1] = 8'h0b; k[2] = 8'h0d; k[3] = 8'h09;
        end else begin
            k[0] = 8'h02; k[1] = 8'h03; k[2] = 8'h01; k[3] = 8'h01;
        end
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gm(k[(j - r + 4) % 4], s[127-8*(4*c+j) -: 8]);
                end
                o[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns cycles until a_out_valid rises, or 99 if it never does within the budget.
    task automatic wait_a(output int cycles);
        cycles = 99;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (a_out_valid === 1'b1) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b1;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_state_i   = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_state_i   = '0;

        step();
        step();
        chk("rst_a_out_valid", 128'(a_out_valid), 128'd0);
        chk("rst_a_state_o",   a_state_o, 128'h0);
        chk("rst_a_in_ready",  128'(a_in_ready), 128'd0);
        chk("rst_b_out_valid", 128'(b_out_valid), 128'd0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 128'(a_in_ready), 128'd1);

        // Known vector
        a_in_valid = 1'b1;
        a_state_i  = V1;
        step();
        a_in_valid = 1'b0;
        chk("calc_in_ready", 128'(a_in_ready), 128'd0);
        wait_a(n);
        chk("known_latency", 128'(n), 128'd4);
        chk("known_result",  a_state_o, R1);

        // Backpressure with a second block pending
        a_in_valid = 1'b1;
        a_state_i  = V2;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_in_ready",  128'(a_in_ready), 128'd0);
            chk("bp_out_valid", 128'(a_out_valid), 128'd1);
            chk("bp_state_o",   a_state_o, R1);
        end
        a_out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", 128'(a_in_ready), 128'd1);
        step();
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        chk("bp_accept_clears_valid", 128'(a_out_valid), 128'd0);
        wait_a(n);
        chk("bp_second_latency", 128'(n), 128'd4);
        chk("roundtrip_ref",     a_state_o, mix(V2, 1'b1));
        chk("roundtrip_fwd",     mix(a_state_o, 1'b0), V2);

        // en=0 in HOLD must ignore the out_ready handshake
        en          = 1'b0;
        a_out_ready = 1'b1;
        step();
        chk("en0_hold_out_valid", 128'(a_out_valid), 128'd1);
        en = 1'b1;
        step();
        a_out_ready = 1'b0;
        chk("hold_to_idle_valid",    128'(a_out_valid), 128'd0);
        chk("hold_to_idle_in_ready", 128'(a_in_ready), 128'd1);

        // en gating after column 1
        a_in_valid = 1'b1;
        a_state_i  = V3;
        step();
        a_in_valid = 1'b0;
        step();
        step();
        en = 1'b0;
        a_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("en0_counter",   128'(dut_a.cnt_q), 128'd2);
            chk("en0_in_ready",  128'(a_in_ready), 128'd0);
            chk("en0_out_valid", 128'(a_out_valid), 128'd0);
        end
        a_in_valid = 1'b0;
        en = 1'b1;
        wait_a(n);
        chk("en_gate_remaining", 128'(n), 128'd2);
        chk("en_gate_result",    a_state_o, mix(V3, 1'b1));
        a_out_ready = 1'b1;
        step();
        a_out_ready = 1'b0;

        // Reset during column 2
        a_in_valid = 1'b1;
        a_state_i  = V1;
        step();
        a_in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(a_out_valid), 128'd0);
        chk("midrst_state_o",   a_state_o, 128'h0);
        chk("midrst_in_ready",  128'(a_in_ready), 128'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_stale", 128'(a_out_valid), 128'd0);
        end

        // Streaming with four columns per cycle
        b_out_ready = 1'b1;
        b_in_valid  = 1'b1;
        b_state_i   = V1;
        step();
        b_state_i = V3;
        step();
        chk("stream0_valid",  128'(b_out_valid), 128'd1);
        chk("stream0_result", b_state_o, R1);
        chk("stream0_ready",  128'(b_in_ready), 128'd1);
        step();
        b_state_i = V4;
        chk("stream1_gap", 128'(b_out_valid), 128'd0);
        step();
        chk("stream1_valid",  128'(b_out_valid), 128'd1);
        chk("stream1_result", b_state_o, mix(V3, 1'b1));
        step();
        b_in_valid = 1'b0;
        chk("stream2_gap", 128'(b_out_valid), 128'd0);
        step();
        chk("stream2_valid",  128'(b_out_valid), 128'd1);
        chk("stream2_result", b_state_o, R4);
        step();
        chk("stream_idle_valid", 128'(b_out_valid), 128'd0);
        chk("stream_idle_ready", 128'(b_in_ready), 128'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
